// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bus of the UART receive FIFO.
//
// Carries the FWFT head entry, occupancy and status from the receiver to
// the register file (RBR/LSR logic), and the pop/flush controls back.
//   slave  : the receiver (drives data/status, takes rd_en/fifo_clr)
//   master : the register file (drives rd_en/fifo_clr, takes data/status)
//
// Signals:
//   fifo_clr    synchronous flush pulse
//   rd_en       pop the head entry
//   rd_data     head character, zero-extended above the data bits
//   rd_pe/fe/bi head parity error / framing error / break indication
//   rx_empty    FIFO empty
//   rx_count    FIFO occupancy, 0..FIFO_DEPTH
//   overrun     one-clk pulse: completed character discarded (FIFO full)
//   rx_timeout  character timeout (only driven non-zero when the timeout
//               feature is built in)
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             fifo_clr;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_pe;
    logic             rd_fe;
    logic             rd_bi;
    logic             rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic             overrun;
    logic             rx_timeout;

    modport slave (
        input  fifo_clr, rd_en,
        output rd_data, rd_pe, rd_fe, rd_bi, rx_empty, rx_count, overrun, rx_timeout
    );

    modport master (
        output fifo_clr, rd_en,
        input  rd_data, rd_pe, rd_fe, rd_bi, rx_empty, rx_count, overrun, rx_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with an FWFT receive FIFO.
//
// Receives 5-8 data bits, optional parity, 1 or 2 stop bits, using a
// 3-sample majority vote around the middle of each bit. Each completed
// character is pushed into the FIFO with its parity/framing/break flags.
// A break (all-zero data, parity and stop) writes a single entry and then
// waits for the line to return high.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rxd            serial input (asynchronous, idle high)
//   sample_tick    one-clk pulse at OVERSAMPLE x baud
//   enable_sample  gate request to the baud generator
//   enable         receiver enable; dropping it aborts a frame in progress
//   data_bits      00=5 .. 11=8 data bits
//   stop_bits      0=1 stop bit, 1=2 stop bits
//   parity_en      parity bit present
//   parity_even    1=even parity, 0=odd parity
//   fifo           read-side bus (uart_rx_fifo_if.slave)
//
// Build option: define UART_RX_TIMEOUT_EN to add the character-timeout
// counter and rx_timeout; otherwise rx_timeout is tied low.
module uart_rx_fifo #(
    parameter  int OVERSAMPLE = 16,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       sample_tick,
    output logic       enable_sample,
    input  logic       enable,
    input  logic [1:0] data_bits,
    input  logic       stop_bits,
    input  logic       parity_en,
    input  logic       parity_even,
    uart_rx_fifo_if.slave fifo
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [TICK_W-1:0] IDX_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] IDX_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] IDX_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] IDX_END  = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BRK_WAIT
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } entry_t;

    // ------------------------------------------------------------------
    // rxd synchroniser
    // ------------------------------------------------------------------
    logic rxd_meta, rxd_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset to the idle (high) line level so reset release does not
            // look like a start bit.
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bit timing and voting
    // ------------------------------------------------------------------
    state_t            state, next_state;
    logic [TICK_W-1:0] tick_idx;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_data;
    logic              s0, s1, par_bit;
    logic [1:0]        cfg_bits;
    logic              cfg_par_en, cfg_par_even, cfg_stop;

    logic at_s0, at_s1, at_vote, at_end;
    logic vote, last_data, brk, pe_calc;
    logic start_det, wr_fire;

    assign at_s0   = sample_tick && (tick_idx == IDX_S0);
    assign at_s1   = sample_tick && (tick_idx == IDX_S1);
    assign at_vote = sample_tick && (tick_idx == IDX_VOTE);
    assign at_end  = sample_tick && (tick_idx == IDX_END);

    // Third sample is taken live at the vote tick.
    assign vote      = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
    assign last_data = (bit_cnt == ({1'b0, cfg_bits} + 3'd4));
    assign brk       = (rx_data == 8'h00) && !(cfg_par_en && par_bit) && !vote;
    // 1 when the received parity bit differs from the one the data implies.
    assign pe_calc   = cfg_par_en & (par_bit ^ (^rx_data) ^ ~cfg_par_even);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        case (state)
            IDLE:     if (!rxd_s) next_state = START;
            START:    if (at_vote && vote) next_state = IDLE;
                      else if (at_end)     next_state = DATA;
            DATA:     if (at_end && last_data) next_state = cfg_par_en ? PARITY : STOP;
            PARITY:   if (at_end) next_state = STOP;
            STOP:     if (at_vote) next_state = brk ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rxd_s) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (!enable) next_state = IDLE;
    end

`ifdef UART_RX_TIMEOUT_EN
    logic to_run;
`endif

    always_comb begin
        start_det = (state == IDLE) && (next_state == START);
        wr_fire   = (state == STOP) && at_vote && enable;
`ifdef UART_RX_TIMEOUT_EN
        enable_sample = enable && ((state != IDLE) || to_run);
`else
        enable_sample = enable && (state != IDLE);
`endif
    end

    // ------------------------------------------------------------------
    // Receive datapath
    // ------------------------------------------------------------------
    logic   wr_req;
    entry_t wr_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_idx     <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            par_bit      <= 1'b0;
            cfg_bits     <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_even <= 1'b0;
            cfg_stop     <= 1'b0;
            wr_req       <= 1'b0;
            wr_entry     <= '0;
        end else begin
            wr_req <= 1'b0;
            if (start_det) begin
                // Frame format is frozen here; mid-frame changes wait for
                // the next start bit.
                tick_idx     <= '0;
                bit_cnt      <= '0;
                rx_data      <= '0;
                par_bit      <= 1'b0;
                cfg_bits     <= data_bits;
                cfg_par_en   <= parity_en;
                cfg_par_even <= parity_even;
                cfg_stop     <= stop_bits;
            end else if (state != IDLE && state != BRK_WAIT && sample_tick) begin
                tick_idx <= at_end ? '0 : tick_idx + TICK_W'(1);
                if (at_s0) s0 <= rxd_s;
                if (at_s1) s1 <= rxd_s;
                if (at_end && state == DATA) bit_cnt <= bit_cnt + 3'd1;
                if (at_vote && state == DATA)   rx_data[bit_cnt] <= vote;
                if (at_vote && state == PARITY) par_bit <= vote;
            end
            if (wr_fire) begin
                wr_req <= 1'b1;
                if (brk) wr_entry <= '{data: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1};
                else     wr_entry <= '{data: rx_data, pe: pe_calc, fe: !vote, bi: 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, do_rd, do_wr, overrun_q;
    entry_t           head;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign do_rd = fifo.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = wr_req && (!full || do_rd);

    // NOTE: the storage array has no reset; validity is tracked by count,
    // and the head outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr && !fifo.fifo_clr) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= wr_req && full && !do_rd && !fifo.fifo_clr;
            if (fifo.fifo_clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({do_wr, do_rd})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign fifo.rd_data  = empty ? 8'h00 : head.data;
    assign fifo.rd_pe    = !empty && head.pe;
    assign fifo.rd_fe    = !empty && head.fe;
    assign fifo.rd_bi    = !empty && head.bi;
    assign fifo.rx_empty = empty;
    assign fifo.rx_count = count;
    assign fifo.overrun  = overrun_q;

    // ------------------------------------------------------------------
    // Character timeout
    // ------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(48 * OVERSAMPLE + 1);

    logic [3:0]      char_bits;
    logic [TO_W-1:0] to_limit, to_cnt;
    logic            to_q, to_clr;

    // Start + data + parity + stop, taken from the last received frame.
    assign char_bits = 4'd7 + {2'b00, cfg_bits} + {3'b000, cfg_par_en} + {3'b000, cfg_stop};
    assign to_limit  = TO_W'(char_bits) * TO_W'(4 * OVERSAMPLE);
    assign to_run    = (state == IDLE) && !empty && !to_q;
    assign to_clr    = fifo.rd_en || start_det || fifo.fifo_clr || empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else if (to_clr) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else if (to_run && sample_tick) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == to_limit - TO_W'(1)) to_q <= 1'b1;
        end
    end

    assign fifo.rx_timeout = to_q;
`else
    // stop_bits only affects the timeout length; without it the second
    // stop bit is simply absorbed as idle line.
    logic cfg_stop_unused;
    assign cfg_stop_unused = cfg_stop;
    assign fifo.rx_timeout = 1'b0;
`endif

endmodule
